commu_rx: RTL and testbench



---
 rtl/commu_pkg.sv | 20 ++
 rtl/bit_div_calc.sv | 64 ++++++
 rtl/commu_rx.sv | 187 ++++++++++++++++++
 tb/tb_commu_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/commu_pkg.sv
// Shared definitions for the commu serial receive path: FSM states, frame constants and counter widths.
package commu_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        STOP_LVL  = 1'b1;
    localparam int unsigned TOTAL_W   = 32;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned DIVD_W    = 32;
    localparam int unsigned DIVS_W    = 16;

    typedef enum logic [2:0] {
        ST_DIV,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_e;

endpackage

// File: rtl/bit_div_calc.sv
// Iterative restoring divider, one quotient bit per cycle; done pulses 34 cycles after start.
module bit_div_calc
    import commu_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIVD_W-1:0] dividend,
    input  logic [DIVS_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DIVD_W-1:0] quot,
    output logic              div0
);

    localparam int unsigned    CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVD_W);

    logic [CNT_W-1:0]  cnt;
    logic [DIVS_W-1:0] rem;
    logic [DIVS_W-1:0] dvs;
    logic [DIVS_W:0]   rem_sh;
    logic [DIVS_W-1:0] diff;
    logic              fits;

    // Shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        rem_sh = {rem, quot[DIVD_W-1]};
        fits   = rem_sh >= {1'b0, dvs};
        diff   = rem_sh[DIVS_W-1:0] - dvs;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            quot <= '0;
            div0 <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                quot <= dividend;
                rem  <= '0;
                dvs  <= divisor;
                div0 <= (divisor == '0);
            end else if (busy) begin
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt  <= cnt + 1'b1;
                    quot <= {quot[DIVD_W-2:0], fits};
                    rem  <= fits ? diff : rem_sh[DIVS_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/commu_rx.sv
// Oversampling serial receiver: recovers start/8-data/stop frames at tbit_fre kbps and counts bits and framing errors.
module commu_rx
    import commu_pkg::*;
#(
    parameter int unsigned CLK_KHZ = 100000,
    parameter int unsigned DIV_MIN = 4
)
(
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               rx,
    input  logic [15:0]        tbit_fre,
    input  logic               clr,
    output logic [TOTAL_W-1:0] rx_total,
    output logic [7:0]         rx_data,
    output logic               rx_vld,
    output logic [ERR_W-1:0]   frm_err_cnt,
    output logic               cfg_ok
);

    localparam int unsigned          IDX_W      = $clog2(DATA_BITS);
    localparam logic [TOTAL_W-1:0]   TOTAL_MAX  = '1;
    localparam logic [TOTAL_W-1:0]   TOTAL_STEP = TOTAL_W'(DATA_BITS);
    localparam logic [ERR_W-1:0]     ERR_MAX    = '1;
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(DATA_BITS - 1);

    rx_state_e         state, state_nxt;
    logic              sync_q1, sync_q2;
    logic [15:0]       tbit_q;
    logic              init_q;
    logic [DIVD_W-1:0] bcnt, bcnt_nxt;
    logic [DIVD_W-1:0] div_q, div_nxt;
    logic [IDX_W-1:0]  bidx, bidx_nxt;
    logic [7:0]        shift, shift_nxt;
    logic [7:0]        data_nxt;
    logic              vld_nxt, cfg_nxt, inc_total, inc_err;
    logic [TOTAL_W-1:0] total_nxt;
    logic [ERR_W-1:0]  err_nxt;

    logic              start_c, fall_c, line_c, bit_end_c, half_end_c, div_ok_c;
    logic              div_busy, div_done, div_zero;
    logic [DIVD_W-1:0] div_quot;

    bit_div_calc u_div (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .start    (start_c),
        .dividend (DIVD_W'(CLK_KHZ)),
        .divisor  (tbit_fre),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .div0     (div_zero)
    );

    // Recompute the divisor after reset and on any rate change.
    always_comb begin
        start_c    = init_q || (tbit_fre != tbit_q);
        fall_c     = !sync_q1 && sync_q2;
        line_c     = sync_q2;
        bit_end_c  = (bcnt == div_q - 1'b1);
        half_end_c = (bcnt == (div_q >> 1) - 1'b1);
        div_ok_c   = !div_zero && (div_quot >= DIVD_W'(DIV_MIN));
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bit_end_c ? '0 : bcnt + 1'b1;
        div_nxt   = div_q;
        bidx_nxt  = bidx;
        shift_nxt = shift;
        data_nxt  = rx_data;
        vld_nxt   = 1'b0;
        cfg_nxt   = cfg_ok;
        inc_total = 1'b0;
        inc_err   = 1'b0;
        case (state)
            ST_DIV: begin
                if (div_done && !div_busy) begin
                    div_nxt = div_quot;
                    cfg_nxt = div_ok_c;
                    if (div_ok_c) state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fall_c) begin
                    bcnt_nxt  = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (half_end_c) begin
                    if (!line_c) begin
                        bcnt_nxt  = '0;
                        bidx_nxt  = '0;
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shift_nxt = {line_c, shift[7:1]};
                    bidx_nxt  = bidx + 1'b1;
                    if (bidx == IDX_LAST) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (line_c == STOP_LVL) begin
                        data_nxt  = shift;
                        vld_nxt   = 1'b1;
                        inc_total = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        inc_err   = 1'b1;
                        state_nxt = ST_BRK;
                    end
                end
            end
            ST_BRK: begin
                if (line_c) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_DIV;
        endcase
        // A rate change abandons any frame in flight without counting it.
        if (start_c) begin
            state_nxt = ST_DIV;
            cfg_nxt   = 1'b0;
            data_nxt  = rx_data;
            vld_nxt   = 1'b0;
            inc_total = 1'b0;
            inc_err   = 1'b0;
        end
    end

    // Saturating counters; clr overrides a coincident increment.
    always_comb begin
        total_nxt = rx_total;
        err_nxt   = frm_err_cnt;
        if (clr) begin
            total_nxt = '0;
            err_nxt   = '0;
        end else begin
            if (inc_total)
                total_nxt = (rx_total > TOTAL_MAX - TOTAL_STEP) ? TOTAL_MAX : rx_total + TOTAL_STEP;
            if (inc_err)
                err_nxt = (frm_err_cnt == ERR_MAX) ? ERR_MAX : frm_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DIV;
            sync_q1     <= 1'b1;
            sync_q2     <= 1'b1;
            tbit_q      <= '0;
            init_q      <= 1'b1;
            bcnt        <= '0;
            div_q       <= '0;
            bidx        <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_vld      <= 1'b0;
            cfg_ok      <= 1'b0;
            rx_total    <= '0;
            frm_err_cnt <= '0;
        end else begin
            state       <= state_nxt;
            sync_q1     <= rx;
            sync_q2     <= sync_q1;
            tbit_q      <= tbit_fre;
            init_q      <= 1'b0;
            bcnt        <= bcnt_nxt;
            div_q       <= div_nxt;
            bidx        <= bidx_nxt;
            shift       <= shift_nxt;
            rx_data     <= data_nxt;
            rx_vld      <= vld_nxt;
            cfg_ok      <= cfg_nxt;
            rx_total    <= total_nxt;
            frm_err_cnt <= err_nxt;
        end
    end

endmodule

// File: tb/tb_commu_rx.sv
// Self-checking bench for commu_rx: random frames against a byte-queue / bit-count model of the receiver.
module tb_commu_rx;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx      = 1'b1;
    logic [15:0] tbit_fre = 16'd5000;
    logic        clr     = 1'b0;
    logic [31:0] rx_total;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [15:0] frm_err_cnt;
    logic        cfg_ok;

    commu_rx dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .rx          (rx),
        .tbit_fre    (tbit_fre),
        .clr         (clr),
        .rx_total    (rx_total),
        .rx_data     (rx_data),
        .rx_vld      (rx_vld),
        .frm_err_cnt (frm_err_cnt),
        .cfg_ok      (cfg_ok)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] model_total = 32'd0;
    int          vld_cnt = 0;
    logic        clr_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: every good frame adds 8 bits (saturating), clr zeroes, bytes arrive in send order.
    always begin
        @(posedge clk_sys);
        clr_s = clr;
        #2;
        if (!rst_n) begin
            model_total = 32'd0;
            check("rst_total", rx_total, 32'd0);
            check("rst_vld", 32'(rx_vld), 32'd0);
            check("rst_data", 32'(rx_data), 32'd0);
            check("rst_err", 32'(frm_err_cnt), 32'd0);
            check("rst_cfg", 32'(cfg_ok), 32'd0);
        end else begin
            if (rx_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) check("vld_unexpected", 32'(rx_vld), 32'd0);
                else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (clr_s) model_total = 32'd0;
            else if (rx_vld) model_total = (model_total > 32'hFFFF_FFF7) ? 32'hFFFF_FFFF : model_total + 32'd8;
            check("rx_total", rx_total, model_total);
        end
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb, input bit expect_rx);
        if (expect_rx) exp_q.push_back(b);
        drive_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
        drive_bit(stop_bit, cpb);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_cfg(input string name, input int lo, input int hi);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk_sys);
            #2;
            n++;
            if (cfg_ok) break;
        end
        checks++;
        if (!cfg_ok || n < lo || n > hi) begin
            errors++;
            $display("FAIL %s: cfg_ok=%0d after %0d cycles, required within %0d..%0d", name, cfg_ok, n, lo, hi);
        end
        @(negedge clk_sys);
    endtask

    initial begin
        int v0;
        logic [7:0] b;

        repeat (3) @(negedge clk_sys);
        check("reset_cfg_ok", 32'(cfg_ok), 32'd0);
        check("reset_total", rx_total, 32'd0);
        rst_n = 1'b1;
        wait_cfg("cfg_latency_5000", 32, 36);

        // Single 0xA5 at 20 clocks per bit
        v0 = vld_cnt;
        idle(10);
        send_frame(8'hA5, 1'b1, 20, 1'b1);
        idle(40);
        check("a5_total", rx_total, 32'd8);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_pulses", 32'(vld_cnt - v0), 32'd1);

        // 13 back-to-back random frames
        clr_pulse();
        v0 = vld_cnt;
        for (int i = 0; i < 13; i++) send_frame(8'($urandom), 1'b1, 20, 1'b1);
        idle(40);
        check("b2b_total", rx_total, 32'd104);
        check("b2b_err", 32'(frm_err_cnt), 32'd0);
        check("b2b_pulses", 32'(vld_cnt - v0), 32'd13);

        // Bad stop bit, line held low, then a good 0x11
        clr_pulse();
        v0 = vld_cnt;
        send_frame(8'h3C, 1'b0, 20, 1'b0);
        drive_bit(1'b0, 50);
        idle(40);
        send_frame(8'h11, 1'b1, 20, 1'b1);
        idle(40);
        check("brk_err", 32'(frm_err_cnt), 32'd1);
        check("brk_total", rx_total, 32'd8);
        check("brk_pulses", 32'(vld_cnt - v0), 32'd1);
        check("brk_data", 32'(rx_data), 32'h11);

        // Short glitch on an idle line
        clr_pulse();
        check("clr_err", 32'(frm_err_cnt), 32'd0);
        v0 = vld_cnt;
        idle($urandom_range(5, 30));
        drive_bit(1'b0, 6);
        idle(80);
        check("glitch_pulses", 32'(vld_cnt - v0), 32'd0);
        check("glitch_err", 32'(frm_err_cnt), 32'd0);
        send_frame(8'($urandom), 1'b1, 20, 1'b1);
        idle(40);
        check("post_glitch_pulses", 32'(vld_cnt - v0), 32'd1);

        // Illegal rates disable the receiver; 1000 kbps re-enables it
        tbit_fre = 16'd0;
        idle(60);
        check("rate0_cfg", 32'(cfg_ok), 32'd0);
        v0 = vld_cnt;
        send_frame(8'($urandom), 1'b1, 20, 1'b0);
        idle(40);
        check("rate0_pulses", 32'(vld_cnt - v0), 32'd0);
        tbit_fre = 16'd40000;
        idle(60);
        check("rate40000_cfg", 32'(cfg_ok), 32'd0);
        tbit_fre = 16'd1000;
        idle(60);
        check("rate1000_cfg", 32'(cfg_ok), 32'd1);
        v0 = vld_cnt;
        send_frame(8'($urandom), 1'b1, 100, 1'b1);
        idle(200);
        check("rate1000_pulses", 32'(vld_cnt - v0), 32'd1);

        // Saturation from a preloaded count
        force dut.rx_total = 32'hFFFF_FFFC;
        model_total = 32'hFFFF_FFFC;
        @(negedge clk_sys);
        @(negedge clk_sys);
        release dut.rx_total;
        idle(5);
        send_frame(8'($urandom), 1'b1, 100, 1'b1);
        idle(200);
        check("sat_total", rx_total, 32'hFFFF_FFFF);

        // clr held across the whole stop bit, so it coincides with the increment
        v0 = vld_cnt;
        b = 8'($urandom);
        exp_q.push_back(b);
        drive_bit(1'b0, 100);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 100);
        rx = 1'b1;
        clr = 1'b1;
        repeat (102) @(negedge clk_sys);
        clr = 1'b0;
        idle(20);
        check("clr_vs_inc_total", rx_total, 32'd0);
        check("clr_vs_inc_pulses", 32'(vld_cnt - v0), 32'd1);

        // Reset during DATA with non-zero outputs
        tbit_fre = 16'd5000;
        idle(60);
        send_frame(8'($urandom), 1'b0, 20, 1'b0);
        drive_bit(1'b0, 30);
        idle(30);
        send_frame(8'h5A, 1'b1, 20, 1'b1);
        idle(30);
        check("pre_rst_err", 32'(frm_err_cnt), 32'd1);
        check("pre_rst_total", rx_total, 32'd8);
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 20);
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 7);
        rst_n = 1'b0;
        #1;
        check("async_rst_total", rx_total, 32'd0);
        check("async_rst_data", 32'(rx_data), 32'd0);
        check("async_rst_err", 32'(frm_err_cnt), 32'd0);
        check("async_rst_cfg", 32'(cfg_ok), 32'd0);
        check("async_rst_vld", 32'(rx_vld), 32'd0);
        exp_q.delete();
        @(negedge clk_sys);
        idle(3);
        rst_n = 1'b1;
        wait_cfg("cfg_latency_rerun", 32, 36);
        v0 = vld_cnt;
        send_frame(8'($urandom), 1'b1, 20, 1'b1);
        idle(40);
        check("post_rst_pulses", 32'(vld_cnt - v0), 32'd1);
        check("post_rst_total", rx_total, 32'd8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
